// File: rtl/axis_defs.sv
// Shared definitions for the AXI-Stream slave FIFO: receive FSM encoding and default widths.
package axis_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port; full/empty decoded from the level counter.
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Head entry is read straight from the array so a popped slot is replaced in the same cycle.
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axis_s_fifo.sv
// AXI-Stream slave buffering beats plus tlast into a FWFT FIFO, with packet framing and error tracking.
module axis_s_fifo
  import axis_defs::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        tvalid,
  output logic                        tready,
  input  logic [DATA_WIDTH-1:0]       tdata,
  input  logic                        tlast,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_last,
  output logic                        empty,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  output logic [$clog2(DEPTH+1)-1:0]  pkt_count,
  output logic                        busy,
  output logic                        pkt_len_err,
  output logic                        underflow
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(MAX_PKT_LEN + 2);

  rx_state_e       state;
  rx_state_e       state_nxt;
  logic [CW-1:0]   beat_cnt;
  logic [CW-1:0]   beat_cnt_nxt;
  logic            len_err_set;
  logic            out_en;
  logic            full;
  logic            push;
  logic            pop;
  logic [DATA_WIDTH:0] rd_word;

  // Holds tready low through reset and releases it on the first edge afterwards.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) out_en <= 1'b0;
    else        out_en <= 1'b1;
  end

  assign tready  = out_en && !full;
  assign push    = tvalid && tready;
  assign pop     = rd_en && !empty;
  assign rd_data = rd_word[DATA_WIDTH-1:0];
  assign rd_last = rd_word[DATA_WIDTH];
  assign busy    = (state == ST_RECV);

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .wr_en   (push),
    .wr_data ({tlast, tdata}),
    .rd_en   (rd_en),
    .rd_data (rd_word),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Receive framing: beat counter saturates one past the legal maximum.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    len_err_set  = 1'b0;
    if (push) begin
      case (state)
        ST_IDLE: begin
          if (!tlast) begin
            state_nxt    = ST_RECV;
            beat_cnt_nxt = CW'(1);
          end else begin
            beat_cnt_nxt = '0;
          end
        end
        ST_RECV: begin
          len_err_set = (beat_cnt >= CW'(MAX_PKT_LEN));
          if (tlast) begin
            state_nxt    = ST_IDLE;
            beat_cnt_nxt = '0;
          end else if (beat_cnt != CW'(MAX_PKT_LEN + 1)) begin
            beat_cnt_nxt = beat_cnt + CW'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_count   <= '0;
      pkt_len_err <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case ({push && tlast, pop && rd_last})
        2'b10:   pkt_count <= pkt_count + LW'(1);
        2'b01:   pkt_count <= pkt_count - LW'(1);
        default: pkt_count <= pkt_count;
      endcase
      if (len_err_set)      pkt_len_err <= 1'b1;
      if (rd_en && empty)   underflow   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_s_fifo.sv
// Directed bench for axis_s_fifo: reset, single beats, fill/stall, streaming wrap, oversize packet, mid-packet reset.
module tb_axis_s_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned DP = 8;
  localparam int unsigned LW = $clog2(DP + 1);

  logic          aclk = 1'b0;
  logic          areset;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          empty;
  logic [LW-1:0] level;
  logic [LW-1:0] pkt_count;
  logic          busy;
  logic          pkt_len_err;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

  axis_s_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DP),
    .MAX_PKT_LEN (16)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .tvalid      (tvalid),
    .tready      (tready),
    .tdata       (tdata),
    .tlast       (tlast),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .empty       (empty),
    .level       (level),
    .pkt_count   (pkt_count),
    .busy        (busy),
    .pkt_len_err (pkt_len_err),
    .underflow   (underflow)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset = 1'b1;
    tvalid = 1'b0;
    tdata  = '0;
    tlast  = 1'b0;
    rd_en  = 1'b0;

    // 1: reset state and tready release
    tick();
    tick();
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flags", 64'({pkt_len_err, underflow}), 64'd0);
    areset = 1'b0;
    #1;
    chk("rel_tready_before_edge", 64'(tready), 64'd0);
    tick();
    chk("rel_tready_after_edge", 64'(tready), 64'd1);

    // 2: two single-beat packets
    tvalid = 1'b1; tdata = 32'hAAAABBBB; tlast = 1'b1;
    tick();
    tdata = 32'hCCCCDDDD;
    tick();
    tvalid = 1'b0;
    chk("single_level", 64'(level), 64'd2);
    chk("single_pkt_count", 64'(pkt_count), 64'd2);
    chk("single_busy", 64'(busy), 64'd0);
    chk("single_head0", 64'(rd_data), 64'hAAAABBBB);
    chk("single_last0", 64'(rd_last), 64'd1);
    rd_en = 1'b1;
    tick();
    chk("single_head1", 64'(rd_data), 64'hCCCCDDDD);
    chk("single_last1", 64'(rd_last), 64'd1);
    chk("single_pkt_after_pop", 64'(pkt_count), 64'd1);
    tick();
    rd_en = 1'b0;
    chk("single_empty", 64'(empty), 64'd1);
    chk("single_pkt_drained", 64'(pkt_count), 64'd0);

    // 3: fill to full, stall, pop one, accept the stalled beat
    for (int i = 0; i < 8; i++) begin
      tvalid = 1'b1; tdata = DW'(i); tlast = (i == 7);
      tick();
      if (i == 0) chk("fill_busy_first", 64'(busy), 64'd1);
    end
    chk("fill_tready", 64'(tready), 64'd0);
    chk("fill_level", 64'(level), 64'd8);
    chk("fill_pkt_count", 64'(pkt_count), 64'd1);
    chk("fill_busy_end", 64'(busy), 64'd0);
    tdata = 32'hDEADBEEF; tlast = 1'b1;
    tick();
    chk("stall_level", 64'(level), 64'd8);
    chk("stall_head", 64'(rd_data), 64'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("stall_pop_tready", 64'(tready), 64'd1);
    chk("stall_pop_level", 64'(level), 64'd7);
    chk("stall_pop_head", 64'(rd_data), 64'd1);
    tick();
    tvalid = 1'b0;
    chk("stall_accept_level", 64'(level), 64'd8);
    chk("stall_accept_pkt", 64'(pkt_count), 64'd2);
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", 64'(rd_data), (i == 8) ? 64'hDEADBEEF : 64'(i));
      chk("drain_last", 64'(rd_last), (i >= 7) ? 64'd1 : 64'd0);
      tick();
    end
    rd_en = 1'b0;
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_pkt_count", 64'(pkt_count), 64'd0);

    // 4: continuous push/pop with pointer wrap, 4-beat packets
    tvalid = 1'b1; tdata = 32'd0; tlast = 1'b0;
    tick();
    for (int c = 1; c < 20; c++) begin
      tdata = DW'(c); tlast = ((c % 4) == 3); rd_en = 1'b1;
      chk("stream_data", 64'(rd_data), 64'(c - 1));
      chk("stream_last", 64'(rd_last), (((c - 1) % 4) == 3) ? 64'd1 : 64'd0);
      chk("stream_level", 64'(level), 64'd1);
      chk("stream_pkt_count", 64'(pkt_count), (((c - 1) % 4) == 3) ? 64'd1 : 64'd0);
      tick();
    end
    tvalid = 1'b0;
    chk("stream_tail_data", 64'(rd_data), 64'd19);
    chk("stream_tail_last", 64'(rd_last), 64'd1);
    tick();
    rd_en = 1'b0;
    chk("stream_empty", 64'(empty), 64'd1);
    chk("stream_pkt_zero", 64'(pkt_count), 64'd0);
    chk("stream_busy", 64'(busy), 64'd0);

    // 5: 17-beat packet overruns the 16-beat limit; then pop on empty
    for (int c = 0; c < 17; c++) begin
      tvalid = 1'b1; tdata = 32'h100 + DW'(c); tlast = (c == 16); rd_en = (c > 0);
      if (c > 0) chk("long_data", 64'(rd_data), 64'h100 + 64'(c - 1));
      if (c == 16) chk("long_err_at_16", 64'(pkt_len_err), 64'd0);
      tick();
    end
    tvalid = 1'b0;
    chk("long_err_at_17", 64'(pkt_len_err), 64'd1);
    chk("long_busy", 64'(busy), 64'd0);
    chk("long_tail_data", 64'(rd_data), 64'h110);
    chk("long_tail_last", 64'(rd_last), 64'd1);
    rd_en = 1'b1;
    tick();
    chk("underflow_before", 64'(underflow), 64'd0);
    tick();
    rd_en = 1'b0;
    chk("underflow_set", 64'(underflow), 64'd1);
    chk("underflow_level", 64'(level), 64'd0);
    chk("underflow_empty", 64'(empty), 64'd1);
    chk("underflow_pkt", 64'(pkt_count), 64'd0);

    // 6: reset mid-packet, then a fresh single-beat packet
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1; tdata = 32'h31 + DW'(i); tlast = 1'b0;
      tick();
    end
    tvalid = 1'b0;
    chk("mid_level", 64'(level), 64'd3);
    chk("mid_busy", 64'(busy), 64'd1);
    areset = 1'b1;
    #1;
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_flags", 64'({pkt_len_err, underflow}), 64'd0);
    chk("mid_rst_tready", 64'(tready), 64'd0);
    tick();
    areset = 1'b0;
    tick();
    chk("post_rst_tready", 64'(tready), 64'd1);
    tvalid = 1'b1; tdata = 32'h12345678; tlast = 1'b1;
    tick();
    tvalid = 1'b0;
    chk("post_rst_data", 64'(rd_data), 64'h12345678);
    chk("post_rst_last", 64'(rd_last), 64'd1);
    chk("post_rst_pkt", 64'(pkt_count), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("post_rst_empty", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
